// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter that sequences loader and cpu accesses onto a
// single byte-wide memory port, one transaction at a time, with a ready-timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_mapped,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              memory_read_en,
  output logic              memory_write_en,
  input  logic              mem_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic             last_grant_c;
  logic             grant_c;
  logic             lat_we;
  logic             err_flag;
  logic [CNT_W-1:0] cnt;

  logic l_elig;
  logic c_elig;
  logic pick_c;

  // On a tie, C wins only when L had the previous grant.
  assign l_elig = l_req;
  assign c_elig = c_req & rom_mapped;
  assign pick_c = c_elig & (~l_elig | ~last_grant_c);

  assign memory_write_en = (state == S_ISSUE) &  lat_we;
  assign memory_read_en  = (state == S_ISSUE) & ~lat_we;
  assign l_ack           = (state == S_DONE)  & ~grant_c;
  assign c_ack           = (state == S_DONE)  &  grant_c;
  assign err             = (state == S_DONE)  &  err_flag;

  // mem_addr/mem_data_in are the latched request, so requesters may change
  // their inputs freely once granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant_c <= 1'b1;
      grant_c      <= 1'b0;
      lat_we       <= 1'b0;
      err_flag     <= 1'b0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      l_rdata      <= '0;
      c_rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l_elig || c_elig) begin
            grant_c      <= pick_c;
            last_grant_c <= pick_c;
            lat_we       <= pick_c ? c_we : l_we;
            mem_addr     <= pick_c ? c_addr : l_addr;
            mem_data_in  <= pick_c ? c_wdata : l_wdata;
            cnt          <= '0;
            err_flag     <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            if (!lat_we) begin
              if (grant_c) c_rdata <= mem_data_out;
              else         l_rdata <= mem_data_out;
            end
            state <= S_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            err_flag <= 1'b1;
            if (!lat_we) begin
              if (grant_c) c_rdata <= '0;
              else         l_rdata <= '0;
            end
            state <= S_DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
